// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - Pong paddle position controller with hold-to-accelerate and AI ball tracking
module paddle_ctrl #(
    parameter int COORD_W     = 9,
    parameter int X_POS       = 8,
    parameter int HEIGHT      = 20,
    parameter int MAX_V       = 240,
    parameter int MIN_V       = 0,
    parameter int START_V     = (MAX_V - MIN_V) / 2,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int AI_SPEED    = 2,
    parameter int DEADBAND    = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               up,
    input  logic               down,
    input  logic               auto_en,
    input  logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] paddle_x,
    output logic [COORD_W-1:0] paddle_y,
    output logic               at_top,
    output logic               at_bottom
);

    localparam int W1 = COORD_W + 1;
    localparam int HW = $clog2(ACCEL_TICKS) + 1;
    localparam logic [COORD_W-1:0] TOP_Y = COORD_W'(MAX_V - HEIGHT);
    localparam logic [COORD_W-1:0] BOT_Y = COORD_W'(MIN_V);

    // IDLE doubles as the "no request" direction.
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t             state, req, nstate;
    logic [COORD_W-1:0] speed, nspeed, step, cap, ny;
    logic [HW-1:0]      hold_cnt, nhold;
    logic               last_auto;
    logic [W1-1:0]      y_ext, centre, ball_ext, sum_up, lim_down;

    always_comb begin
        y_ext    = {1'b0, paddle_y};
        centre   = y_ext + W1'(HEIGHT / 2);
        ball_ext = {1'b0, ball_y};
        cap      = auto_en ? COORD_W'(AI_SPEED) : COORD_W'(MAX_SPEED);

        req = IDLE;
        if (auto_en) begin
            if (ball_ext > centre + W1'(DEADBAND))
                req = UP;
            else if (ball_ext + W1'(DEADBAND) < centre)
                req = DOWN;
        end else if (up && !down) begin
            req = UP;
        end else if (down && !up) begin
            req = DOWN;
        end

        nstate = state;
        nspeed = speed;
        nhold  = hold_cnt;
        step   = '0;
        if (req == IDLE) begin
            nstate = IDLE;
            nspeed = COORD_W'(1);
            nhold  = '0;
        end else if (req != state || auto_en != last_auto) begin
            nstate = req;
            step   = COORD_W'(1);
            nspeed = COORD_W'(1);
            nhold  = HW'(1);
        end else begin
            // Step is capped too, so a lower cap takes effect immediately.
            step = (speed > cap) ? cap : speed;
            if (hold_cnt == HW'(ACCEL_TICKS - 1)) begin
                nspeed = (speed >= cap) ? cap : speed + COORD_W'(1);
                nhold  = '0;
            end else begin
                nhold = hold_cnt + HW'(1);
            end
        end

        sum_up   = y_ext + {1'b0, step} + W1'(HEIGHT);
        lim_down = W1'(MIN_V) + {1'b0, step};
        ny       = paddle_y;
        if (nstate == UP) begin
            if (sum_up > W1'(MAX_V)) begin
                ny     = TOP_Y;
                nspeed = COORD_W'(1);
                nhold  = '0;
            end else begin
                ny = paddle_y + step;
            end
        end else if (nstate == DOWN) begin
            if (y_ext < lim_down) begin
                ny     = BOT_Y;
                nspeed = COORD_W'(1);
                nhold  = '0;
            end else begin
                ny = paddle_y - step;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            paddle_x  <= COORD_W'(X_POS);
            paddle_y  <= COORD_W'(START_V);
            at_top    <= (START_V == MAX_V - HEIGHT);
            at_bottom <= (START_V == MIN_V);
            state     <= IDLE;
            speed     <= COORD_W'(1);
            hold_cnt  <= '0;
            last_auto <= 1'b0;
        end else begin
            paddle_x <= COORD_W'(X_POS);
            if (tick) begin
                paddle_y  <= ny;
                at_top    <= (ny == TOP_Y);
                at_bottom <= (ny == BOT_Y);
                state     <= nstate;
                speed     <= nspeed;
                hold_cnt  <= nhold;
                last_auto <= auto_en;
            end
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - table-driven scoreboard bench for paddle_ctrl
module tb_paddle_ctrl;

    logic       clock;
    logic       reset, tick, up, down, auto_en;
    logic [8:0] ball_y;
    logic [8:0] paddle_x, paddle_y;
    logic       at_top, at_bottom;

    paddle_ctrl dut (
        .clock(clock), .reset(reset), .tick(tick), .up(up), .down(down),
        .auto_en(auto_en), .ball_y(ball_y), .paddle_x(paddle_x),
        .paddle_y(paddle_y), .at_top(at_top), .at_bottom(at_bottom)
    );

    typedef struct {
        bit rst;
        bit tk;
        bit u;
        bit dn;
        bit ae;
        int by;
        int y;
        int idx;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   ey;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input bit rst, input bit tk, input bit u, input bit dn,
                       input bit ae, input int by, input int y);
        tbl.push_back('{rst, tk, u, dn, ae, by, y, tbl.size()});
    endtask

    function automatic int mstep(input int i, input int cap);
        int s;
        s = 1 + (i - 1) / 8;
        return (s > cap) ? cap : s;
    endfunction

    always @(posedge clock) begin
        vec_t v;
        #1;
        if (sb.size() > 0) begin
            v = sb.pop_front();
            checks++;
            if (paddle_x !== 9'd8 || paddle_y !== 9'(v.y) ||
                at_top !== (v.y == 220) || at_bottom !== (v.y == 0)) begin
                errors++;
                $display("FAIL row%0d: got x=%0d y=%0d top=%b bot=%b, want x=8 y=%0d top=%b bot=%b",
                         v.idx, paddle_x, paddle_y, at_top, at_bottom,
                         v.y, (v.y == 220), (v.y == 0));
            end
        end
    end

    initial begin
        reset = 1'b1; tick = 1'b0; up = 1'b0; down = 1'b0; auto_en = 1'b0; ball_y = '0;

        // Reset, then tick=0 must freeze the paddle despite up=1.
        add(1, 0, 0, 0, 0, 0, 120);
        for (int i = 0; i < 20; i++) add(0, 0, 1, 0, 0, 0, 120);

        // Up held: acceleration every 8 ticks, run into the top edge.
        ey = 120;
        for (int i = 1; i <= 41; i++) begin
            ey = ey + mstep(i, 4);
            if (ey > 220) ey = 220;
            add(0, 1, 1, 0, 0, 0, ey);
        end
        add(0, 1, 0, 1, 0, 0, 219);
        add(0, 1, 0, 1, 0, 0, 218);
        add(0, 1, 0, 1, 0, 0, 217);
        add(0, 1, 0, 0, 0, 0, 217);
        add(0, 1, 1, 0, 0, 0, 218);
        add(0, 1, 1, 0, 0, 0, 219);
        add(0, 1, 1, 0, 0, 0, 220);
        add(0, 1, 1, 0, 0, 0, 220);

        // Reach 217 at speed 4, next tick clamps to the top.
        add(1, 0, 0, 0, 0, 0, 120);
        add(0, 1, 1, 0, 0, 0, 121);
        add(0, 1, 0, 0, 0, 0, 121);
        ey = 121;
        for (int i = 1; i <= 39; i++) begin
            ey = ey + mstep(i, 4);
            if (ey > 220) ey = 220;
            add(0, 1, 1, 0, 0, 0, ey);
        end
        add(0, 1, 0, 1, 0, 0, 219);

        // Both buttons mid-acceleration, then down to the bottom edge.
        add(1, 0, 0, 0, 0, 0, 120);
        for (int i = 1; i <= 10; i++) add(0, 1, 1, 0, 0, 0, 120 + ((i <= 8) ? i : 8 + 2 * (i - 8)));
        for (int i = 0; i < 5; i++) add(0, 1, 1, 1, 0, 0, 132);
        add(0, 1, 1, 0, 0, 0, 133);
        ey = 133;
        for (int i = 1; i <= 46; i++) begin
            ey = ey - mstep(i, 4);
            if (ey < 0) ey = 0;
            add(0, 1, 0, 1, 0, 0, ey);
        end
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 2);
        add(0, 1, 1, 0, 0, 0, 3);
        add(0, 1, 0, 0, 0, 0, 3);
        add(0, 1, 0, 1, 0, 0, 2);
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0);

        // Auto mode: deadband, tracking up with cap 2, tracking down.
        add(1, 0, 0, 0, 0, 0, 120);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1, 131, 120);
        for (int i = 1; i <= 20; i++) add(0, 1, 0, 0, 1, 200, (i <= 8) ? 120 + i : 128 + 2 * (i - 8));
        for (int i = 1; i <= 4; i++) add(0, 1, 0, 0, 1, 100, 152 - i);
        add(0, 1, 0, 0, 1, 160, 148);
        add(0, 1, 0, 0, 1, 156, 148);
        add(0, 1, 0, 0, 1, 161, 149);
        add(0, 1, 1, 0, 0, 0, 150);

        // Reset on a tick during movement wins.
        add(1, 0, 0, 0, 0, 0, 120);
        for (int i = 1; i <= 12; i++) add(0, 1, 1, 0, 0, 0, 120 + ((i <= 8) ? i : 8 + 2 * (i - 8)));
        add(1, 1, 1, 0, 0, 0, 120);
        add(0, 1, 1, 0, 0, 0, 121);
        add(0, 1, 1, 0, 0, 0, 122);

        foreach (tbl[k]) begin
            @(negedge clock);
            reset   = tbl[k].rst;
            tick    = tbl[k].tk;
            up      = tbl[k].u;
            down    = tbl[k].dn;
            auto_en = tbl[k].ae;
            ball_y  = 9'(tbl[k].by);
            sb.push_back(tbl[k]);
        end
        @(negedge clock);
        tick = 1'b0;
        for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
